// File: rtl/obstacle_game_core.sv
// ============================================================================
// obstacle_game_core
// ----------------------------------------------------------------------------
// Game engine that sits behind the VGA pixel path. It keeps NUM_OBJ falling
// square obstacles, one player ship on a fixed row, a lives counter and a
// PLAY / HIT / OVER state machine. All game state advances once per frame on
// i_frame_tick. The pixel colour for the current scan position is produced
// every clock with one cycle of latency.
//
// Ports:
//   i_clk          pixel/system clock
//   i_reset_n      asynchronous active-low reset
//   i_frame_tick   one-cycle pulse per frame (start of vertical blank)
//   i_move_left    level, sampled on i_frame_tick
//   i_move_right   level, sampled on i_frame_tick
//   i_restart      level, sampled on i_frame_tick
//   i_column       current scan column (COORD_W bits, unsigned)
//   i_row          current scan row    (COORD_W bits, unsigned)
//   i_active       high inside the visible display region
//   o_rgb          registered {R[3:0],G[3:0],B[3:0]}
//   o_lives        remaining lives
//   o_hit          one-cycle pulse on the frame a life is lost
//   o_game_over    high while in the OVER state
//   o_score        obstacles dodged
//
// Optional feature macro: OBSTACLE_GAME_SCORE_EN
//   defined   -> o_score counts obstacles that wrap past the bottom edge in
//                PLAY/HIT frames, saturating at all-ones, cleared on restart
//   undefined -> o_score is tied to zero and no counter is built
// ============================================================================
module obstacle_game_core #(
    parameter int NUM_OBJ         = 5,
    parameter int COORD_W         = 11,
    parameter int H_ACTIVE        = 800,
    parameter int V_ACTIVE        = 600,
    parameter int OBJ_SIZE        = 20,
    parameter int OBJ_X0          = 20,
    parameter int OBJ_PITCH       = 40,
    parameter int OBJ_STAGGER     = 50,
    parameter int FALL_STEP       = 5,
    parameter int SHIP_SIZE       = 20,
    parameter int SHIP_Y          = 440,
    parameter int SHIP_X_INIT     = 2,
    parameter int SHIP_STEP       = 2,
    parameter int LIVES           = 3,
    parameter int COOLDOWN_FRAMES = 60,
    parameter int SCORE_W         = 12
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_frame_tick,
    input  logic               i_move_left,
    input  logic               i_move_right,
    input  logic               i_restart,
    input  logic [COORD_W-1:0] i_column,
    input  logic [COORD_W-1:0] i_row,
    input  logic               i_active,
    output logic [11:0]        o_rgb,
    output logic [2:0]         o_lives,
    output logic               o_hit,
    output logic               o_game_over,
    output logic [SCORE_W-1:0] o_score
);

    // Positions are signed so obstacles can sit partly above the screen.
    localparam int PW = COORD_W + 1;

    // Cooldown needs at least bit 2 for the blink pattern.
    localparam int CD_BITS = $clog2(COOLDOWN_FRAMES + 1);
    localparam int CD_W    = (CD_BITS < 3) ? 3 : CD_BITS;

    localparam logic signed [PW-1:0] SHIP_X_INIT_S = PW'(SHIP_X_INIT);
    localparam logic signed [PW-1:0] SHIP_X_MAX_S  = PW'(H_ACTIVE - SHIP_SIZE);
    localparam logic signed [PW-1:0] SHIP_STEP_S   = PW'(SHIP_STEP);
    localparam logic signed [PW-1:0] SHIP_SIZE_S   = PW'(SHIP_SIZE);
    localparam logic signed [PW-1:0] SHIP_Y_S      = PW'(SHIP_Y);
    localparam logic signed [PW-1:0] OBJ_SIZE_S    = PW'(OBJ_SIZE);
    localparam logic signed [PW-1:0] FALL_S        = PW'(FALL_STEP);
    localparam logic signed [PW-1:0] V_ACTIVE_S    = PW'(V_ACTIVE);
    localparam logic signed [PW-1:0] WRAP_Y_S      = PW'(-OBJ_SIZE);

    localparam logic [2:0]      LIVES_INIT = 3'(LIVES);
    localparam logic [CD_W-1:0] CD_INIT    = CD_W'(COOLDOWN_FRAMES);
    localparam logic [CD_W-1:0] CD_ONE     = CD_W'(1);

    localparam logic [11:0] C_BACKGROUND = 12'hFB5;
    localparam logic [11:0] C_OBSTACLE   = 12'h8B7;
    localparam logic [11:0] C_SHIP       = 12'h1BF;
    localparam logic [11:0] C_SHIP_OVER  = 12'hF00;

    typedef enum logic [1:0] {
        ST_PLAY,
        ST_HIT,
        ST_OVER
    } state_t;

    // Fixed left edge of obstacle idx.
    function automatic logic signed [PW-1:0] objX(input int idx);
        return PW'(OBJ_X0 + idx * OBJ_PITCH);
    endfunction

    // Staggered start height of obstacle idx (above the screen for idx > 0).
    function automatic logic signed [PW-1:0] objInitY(input int idx);
        return PW'(-(idx * OBJ_STAGGER));
    endfunction

    state_t                r_state;
    logic signed [PW-1:0]  r_ship_x;
    logic signed [PW-1:0]  r_obj_y [NUM_OBJ];
    logic [2:0]            r_lives;
    logic [CD_W-1:0]       r_cooldown;
    logic                  r_hit;
    logic [11:0]           r_rgb;

    logic                  w_collide;
    logic signed [PW-1:0]  w_ship_next;
    logic signed [PW-1:0]  w_obj_next [NUM_OBJ];
    logic [NUM_OBJ-1:0]    w_obj_wrap;
    logic signed [PW-1:0]  w_col;
    logic signed [PW-1:0]  w_row;
    logic                  w_in_ship;
    logic                  w_in_obj;
    logic                  w_ship_visible;
    logic [11:0]           w_pixel;

    // Box-overlap test between the ship and every obstacle, using the
    // positions held before this frame's motion is applied.
    always_comb begin
        w_collide = 1'b0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if ((r_ship_x < objX(i) + OBJ_SIZE_S) &&
                (objX(i) < r_ship_x + SHIP_SIZE_S) &&
                (SHIP_Y_S < r_obj_y[i] + OBJ_SIZE_S) &&
                (r_obj_y[i] < SHIP_Y_S + SHIP_SIZE_S)) begin
                w_collide = 1'b1;
            end
        end
    end

    // Ship moves only when exactly one direction is requested and is
    // clamped against both screen edges instead of wrapping.
    always_comb begin
        w_ship_next = r_ship_x;
        if (i_move_left && !i_move_right) begin
            if (r_ship_x < SHIP_STEP_S) begin
                w_ship_next = '0;
            end else begin
                w_ship_next = r_ship_x - SHIP_STEP_S;
            end
        end else if (i_move_right && !i_move_left) begin
            if (r_ship_x > SHIP_X_MAX_S - SHIP_STEP_S) begin
                w_ship_next = SHIP_X_MAX_S;
            end else begin
                w_ship_next = r_ship_x + SHIP_STEP_S;
            end
        end
    end

    // Obstacles fall a fixed step; one that passes the bottom edge restarts
    // just above the top so it slides back into view.
    always_comb begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            w_obj_wrap[i] = (r_obj_y[i] + FALL_S >= V_ACTIVE_S);
            if (w_obj_wrap[i]) begin
                w_obj_next[i] = WRAP_Y_S;
            end else begin
                w_obj_next[i] = r_obj_y[i] + FALL_S;
            end
        end
    end

    // Frame-rate game state machine. Restart beats everything, OVER freezes
    // the playfield, HIT is the invulnerable window after losing a life.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ST_PLAY;
            r_ship_x   <= SHIP_X_INIT_S;
            r_lives    <= LIVES_INIT;
            r_cooldown <= '0;
            r_hit      <= 1'b0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                r_obj_y[i] <= objInitY(i);
            end
        end else begin
            r_hit <= 1'b0;
            if (i_frame_tick) begin
                if (i_restart) begin
                    r_state    <= ST_PLAY;
                    r_ship_x   <= SHIP_X_INIT_S;
                    r_lives    <= LIVES_INIT;
                    r_cooldown <= '0;
                    for (int i = 0; i < NUM_OBJ; i++) begin
                        r_obj_y[i] <= objInitY(i);
                    end
                end else if (r_state != ST_OVER) begin
                    r_ship_x <= w_ship_next;
                    for (int i = 0; i < NUM_OBJ; i++) begin
                        r_obj_y[i] <= w_obj_next[i];
                    end
                    case (r_state)
                        ST_PLAY: begin
                            if (w_collide) begin
                                r_hit <= 1'b1;
                                if (r_lives > 3'd1) begin
                                    r_lives    <= r_lives - 3'd1;
                                    r_cooldown <= CD_INIT;
                                    r_state    <= ST_HIT;
                                end else begin
                                    r_lives <= 3'd0;
                                    r_state <= ST_OVER;
                                end
                            end
                        end
                        ST_HIT: begin
                            r_cooldown <= r_cooldown - CD_ONE;
                            if (r_cooldown == CD_ONE) begin
                                r_state <= ST_PLAY;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    // Scan coordinates are unsigned; a zero sign bit lets them be compared
    // directly against obstacle heights that may still be negative.
    assign w_col = {1'b0, i_column};
    assign w_row = {1'b0, i_row};

    // Strict-interior hit tests and colour priority ship > obstacle > sky.
    // While invulnerable the ship blinks on cooldown bit 2.
    always_comb begin
        w_in_ship = (w_col > r_ship_x) && (w_col < r_ship_x + SHIP_SIZE_S) &&
                    (w_row > SHIP_Y_S) && (w_row < SHIP_Y_S + SHIP_SIZE_S);
        w_in_obj = 1'b0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if ((w_col > objX(i)) && (w_col < objX(i) + OBJ_SIZE_S) &&
                (w_row > r_obj_y[i]) && (w_row < r_obj_y[i] + OBJ_SIZE_S)) begin
                w_in_obj = 1'b1;
            end
        end
        w_ship_visible = (r_state != ST_HIT) || !r_cooldown[2];
        if (!i_active) begin
            w_pixel = 12'h000;
        end else if (w_in_ship && w_ship_visible) begin
            w_pixel = (r_state == ST_OVER) ? C_SHIP_OVER : C_SHIP;
        end else if (w_in_obj) begin
            w_pixel = C_OBSTACLE;
        end else begin
            w_pixel = C_BACKGROUND;
        end
    end

    // Output colour register, one cycle behind the scan position.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rgb <= 12'h000;
        end else begin
            r_rgb <= w_pixel;
        end
    end

`ifdef OBSTACLE_GAME_SCORE_EN
    logic [3:0]         w_wrap_cnt;
    logic [SCORE_W:0]   w_score_sum;
    logic [SCORE_W-1:0] r_score;

    // Number of obstacles wrapping this frame.
    always_comb begin
        w_wrap_cnt = 4'd0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (w_obj_wrap[i]) begin
                w_wrap_cnt = w_wrap_cnt + 4'd1;
            end
        end
    end

    // One extra bit catches overflow so the score saturates.
    assign w_score_sum = {1'b0, r_score} + {{(SCORE_W - 3){1'b0}}, w_wrap_cnt};

    // Dodge counter; frozen in OVER, cleared by restart.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_score <= '0;
        end else if (i_frame_tick) begin
            if (i_restart) begin
                r_score <= '0;
            end else if (r_state != ST_OVER) begin
                r_score <= w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];
            end
        end
    end

    assign o_score = r_score;
`else
    assign o_score = '0;
`endif

    assign o_rgb       = r_rgb;
    assign o_lives     = r_lives;
    assign o_hit       = r_hit;
    assign o_game_over = (r_state == ST_OVER);

endmodule
